// File: rtl/aes_decrypt_core_if.sv
// aes_decrypt_core_if: key load, ciphertext in and plaintext out handshakes of the AES-128 decrypt core
interface aes_decrypt_core_if;
  logic         key_load;
  logic [127:0] key;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  modport master (
    output key_load, key, in_valid, ciphertext, out_ready,
    input  key_ready, in_ready, out_valid, plaintext
  );
  modport slave (
    input  key_load, key, in_valid, ciphertext, out_ready,
    output key_ready, in_ready, out_valid, plaintext
  );
endinterface

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core: iterative AES-128 inverse cipher, one round per clk, keys expanded forward then used in reverse.
// AES_DEC_ZEROIZE_EN: clears plaintext/state after each output handshake and clears round keys on reset.
module aes_decrypt_core #(
  parameter int KEY_SIZE = 128
) (
  input logic clk,
  input logic reset,
  aes_decrypt_core_if.slave bus
);
  typedef enum logic [2:0] {IDLE, KEXP, READY, DEC, DONE} state_t;
  if (KEY_SIZE != 128) begin : g_bad_key_size
    $fatal(1, "aes_decrypt_core: only KEY_SIZE=128 is supported");
  end
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xt(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254 through a short square-and-multiply chain
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(a15, a15);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv(rl(a, 1) ^ rl(a, 3) ^ rl(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] r;
    r = 8'h01;
    for (int j = 1; j < 10; j++) r = (j < int'(n)) ? xt(r) : r;
    return r;
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic mix);
    logic [127:0] t;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = isbox(s[127-8*(4*((c-r+4)%4)+r) -: 8]);
    t = t ^ k;
    if (!mix) return t;
    for (int c = 0; c < 4; c++) begin
      a0 = t[127-32*c -: 8];
      a1 = t[119-32*c -: 8];
      a2 = t[111-32*c -: 8];
      a3 = t[103-32*c -: 8];
      t[127-32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return t;
  endfunction
  state_t       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] blk_q, blk_d, pt_q, pt_d, rnd_out;
  logic         key_ready_q, key_ready_d, out_valid_q, out_valid_d;
  logic [127:0] rk_q [0:10];
  logic [127:0] rk_d [0:10];
  assign bus.in_ready  = state_q == READY && !bus.key_load;
  assign bus.key_ready = key_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.plaintext = pt_q;
  // rnd_q doubles as the key-expansion index in KEXP and the round index in DEC
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    blk_d       = blk_q;
    pt_d        = pt_q;
    key_ready_d = key_ready_q;
    out_valid_d = out_valid_q;
    rk_d        = rk_q;
    rnd_out     = inv_round(blk_q, rk_q[rnd_q], rnd_q != 4'd0);
    case (state_q)
      IDLE: if (bus.key_load) begin
        rk_d[0] = bus.key;
        rnd_d   = 4'd1;
        state_d = KEXP;
      end
      KEXP: if (rnd_q == 4'd11) begin
        rnd_d       = 4'd0;
        key_ready_d = 1'b1;
        state_d     = READY;
      end else begin
        rk_d[rnd_q] = next_key(rk_q[rnd_q - 4'd1], rcon(rnd_q));
        rnd_d       = rnd_q + 4'd1;
      end
      READY: if (bus.key_load) begin
        rk_d[0]     = bus.key;
        rnd_d       = 4'd1;
        key_ready_d = 1'b0;
        state_d     = KEXP;
      end else if (bus.in_valid) begin
        blk_d   = bus.ciphertext ^ rk_q[10];
        rnd_d   = 4'd9;
        state_d = DEC;
      end
      DEC: begin
        blk_d       = rnd_out;
        rnd_d       = rnd_q == 4'd0 ? rnd_q : rnd_q - 4'd1;
        pt_d        = rnd_q == 4'd0 ? rnd_out : pt_q;
        out_valid_d = rnd_q == 4'd0;
        state_d     = rnd_q == 4'd0 ? DONE : DEC;
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        state_d     = READY;
`ifdef AES_DEC_ZEROIZE_EN
        pt_d  = '0;
        blk_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_DEC_ZEROIZE_EN
    if (reset) rk_d = '{default: '0};
`endif
  end
  always_ff @(posedge clk) begin
    rk_q <= rk_d;
    if (reset) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      blk_q       <= '0;
      pt_q        <= '0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      blk_q       <= blk_d;
      pt_q        <= pt_d;
      key_ready_q <= key_ready_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// tb_aes_decrypt_core: directed FIPS-197 vectors against a byte-level inverse-cipher model with a per-cycle compare.
module tb_aes_decrypt_core;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  aes_decrypt_core_if bus();
  aes_decrypt_core dut (.clk(clk), .reset(reset), .bus(bus));
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  // S-box tables: brute-force field inverse, bitwise affine map, inverse table by lookup reversal
  task automatic build_sbox();
    logic [7:0] c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] v, b;
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        b[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      sb[x]  = b;
      isb[b] = 8'(x);
    end
  endtask
  function automatic logic [127:0] rkey(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 4*(n+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction
  function automatic logic [127:0] decrypt(input logic [127:0] key, input logic [127:0] ct);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] cf [4];
    logic [127:0] k, res;
    cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    k = rkey(key, 10);
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 9; r >= 0; r--) begin
      k = rkey(key, r);
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[4*((c+row)%4)+row] = isb[s[4*c+row]];
      for (int i = 0; i < 16; i++) t[i] ^= k[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          s[4*c+row] = (r == 0) ? t[4*c+row] : 8'h00;
          if (r != 0)
            for (int j = 0; j < 4; j++) s[4*c+row] ^= gm(t[4*c+j], cf[(j-row+4)%4]);
        end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction
  // transaction-level model: key-expansion countdown, block-in-flight countdown, held output
  logic m_kr = 1'b0, m_busy = 1'b0, m_ov = 1'b0;
  int m_kcnt = 0, m_bcnt = 0;
  logic [127:0] m_key = '0, m_pt = '0, m_pend = '0;
  always @(posedge clk) begin
    if (reset) begin
      m_kr <= 1'b0; m_kcnt <= 0; m_busy <= 1'b0; m_bcnt <= 0; m_ov <= 1'b0; m_pt <= '0;
    end else begin
      if (m_kcnt > 0) begin
        m_kcnt <= m_kcnt - 1;
        if (m_kcnt == 1) m_kr <= 1'b1;
      end
      if (m_busy) begin
        m_bcnt <= m_bcnt - 1;
        if (m_bcnt == 1) begin m_busy <= 1'b0; m_ov <= 1'b1; m_pt <= m_pend; end
      end else if (m_ov) begin
        if (bus.out_ready) begin
          m_ov <= 1'b0;
`ifdef AES_DEC_ZEROIZE_EN
          m_pt <= '0;
`endif
        end
      end else if (m_kcnt == 0 && bus.key_load) begin
        m_kr <= 1'b0; m_kcnt <= 11; m_key <= bus.key;
      end else if (m_kr && bus.in_valid) begin
        m_busy <= 1'b1; m_bcnt <= 10; m_pend <= decrypt(m_key, bus.ciphertext);
      end
    end
  end
  always @(negedge clk) begin
    check("key_ready", bus.key_ready, m_kr);
    check("in_ready", bus.in_ready, m_kr && !m_busy && !m_ov && !bus.key_load);
    check("out_valid", bus.out_valid, m_ov);
    check("plaintext", bus.plaintext, m_pt);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load_key(input logic [127:0] k);
    int e0, n;
    bus.key_load = 1'b1;
    bus.key = k;
    step();
    bus.key_load = 1'b0;
    e0 = cyc;
    n = 0;
    while (!bus.key_ready && n < 30) begin step(); n++; end
    check("key_ready_latency", 128'(cyc - e0), 128'd11);
  endtask
  task automatic send(input logic [127:0] ct, output int acc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.ciphertext = ct;
    while (!bus.in_ready && n < 40) begin step(); n++; end
    check("accept", bus.in_ready, 1'b1);
    step();
    acc = cyc;
    bus.in_valid = 1'b0;
  endtask
  task automatic recv(input int acc, input logic [127:0] exp, input string nm);
    int n = 0;
    while (!bus.out_valid && n < 40) begin step(); n++; end
    check({nm, "_latency"}, 128'(cyc - acc), 128'd10);
    check({nm, "_pt"}, bus.plaintext, exp);
  endtask
  task automatic no_key_probe(input string nm);
    int hits = 0;
    bus.in_valid = 1'b1;
    bus.ciphertext = C1;
    repeat (15) begin step(); if (bus.in_ready) hits++; end
    bus.in_valid = 1'b0;
    check(nm, 128'(hits), 128'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, n, bad;
    bus.key_load = 1'b0; bus.key = '0; bus.in_valid = 1'b0; bus.ciphertext = '0; bus.out_ready = 1'b1;
    build_sbox();
    check("model_c1", decrypt(K1, C1), P1);
    check("model_appb", decrypt(K2, C2), P2);
    check("model_rk10", rkey(K2, 10), R10);
    repeat (3) step();
    reset = 1'b0;
    check("rst_key_ready", bus.key_ready, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_plaintext", bus.plaintext, '0);
    no_key_probe("nokey_after_reset");
    load_key(K1);
    send(C1, acc);
    recv(acc, P1, "fips_c1");
    step();
    load_key(K2);
    check("dut_rk10", dut.rk_q[10], R10);
    send(C2, acc);
    recv(acc, P2, "fips_b");
    step();
    bus.out_ready = 1'b0;
    send(C2, acc);
    recv(acc, P2, "bp");
    bus.in_valid = 1'b1;
    bus.ciphertext = C1;
    bad = 0;
    repeat (20) begin
      step();
      if (bus.plaintext !== P2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
    end
    check("bp_hold", 128'(bad), 128'd0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    check("bp_release_in_ready", bus.in_ready, 1'b1);
    check("bp_release_out_valid", bus.out_valid, 1'b0);
    send(C2, acc);
    repeat (2) step();
    bus.key_load = 1'b1;
    bus.key = K1;
    step();
    bus.key_load = 1'b0;
    check("dec_keyload_key_ready", bus.key_ready, 1'b1);
    recv(acc, P2, "dec_keyload_ignored");
    step();
    send(C2, acc);
    recv(acc, P2, "old_key_kept");
    step();
    bus.key_load = 1'b1; bus.key = K1; bus.in_valid = 1'b1; bus.ciphertext = C1;
    #1;
    check("rekey_in_ready", bus.in_ready, 1'b0);
    step();
    bus.key_load = 1'b0;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.key_ready && n < 30) begin n++; step(); end
    check("rekey_key_ready_low", 128'(n), 128'd11);
    check("rekey_no_block", bus.out_valid, 1'b0);
    send(C1, acc);
    repeat (4) step();
    check("mid_dec_round", 128'(dut.rnd_q), 128'd5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_key_ready", bus.key_ready, 1'b0);
    check("mid_rst_in_ready", bus.in_ready, 1'b0);
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_plaintext", bus.plaintext, '0);
    no_key_probe("nokey_after_mid_reset");
    load_key(K1);
    for (int i = 0; i < 4; i++) begin
      send(C1, acc);
      recv(acc, P1, "b2b");
      step();
      check("b2b_in_ready", bus.in_ready, 1'b1);
`ifdef AES_DEC_ZEROIZE_EN
      check("b2b_zeroized", bus.plaintext, '0);
`else
      check("b2b_held", bus.plaintext, P1);
`endif
    end
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
